// File: rtl/spectro_readout_sequencer.sv
// rtl/spectro_readout_sequencer.sv - frame readout sequencer: channel scan, word load/shift pacing, accumulator clear (optional stall abort: SEQ_STALL_TIMEOUT_EN)
module spectro_readout_sequencer #(
    parameter int NUM_CH      = 16,
    parameter int SEL_W       = 4,
    parameter int WORD_BITS   = 12,
    parameter int BIT_W       = 4,
    parameter int CLR_CYCLES  = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              out_ready,
    input  logic              ovr_clr,
    output logic [SEL_W-1:0]  sel,
    output logic              sl,
    output logic              shift_en,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              ch_rst,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              timeout
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic               ovr_q, ovr_d;

    logic               first_vld;
    logic [SEL_W-1:0]   first_idx;
    logic               next_vld;
    logic [SEL_W-1:0]   next_idx;
    logic               xfer;
    logic               word_end;
    logic               clr_last;
    logic               stall_hit;

`ifdef SEQ_STALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0]    stall_q, stall_d;
    logic               to_q, to_d;

    // Stall watchdog: counts consecutive un-ready SHIFT cycles, aborts the frame at the limit.
    always_comb begin
        stall_hit = (state_q == ST_SHIFT) && !out_ready && (stall_q == TO_W'(TIMEOUT_CYC - 1));
        stall_d   = '0;
        if ((state_q == ST_SHIFT) && !out_ready && !stall_hit) begin
            stall_d = stall_q + 1'b1;
        end
        to_d = to_q | stall_hit;
    end

    // Stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            stall_q <= stall_d;
            to_q    <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign stall_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Channel search: lowest enabled channel of the live mask (frame start) and the
    // next enabled channel above the current one in the captured mask (no wrap).
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_vld = 1'b1;
                first_idx = SEL_W'(i);
            end
        end
        next_vld = 1'b0;
        next_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_vld = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

    assign xfer     = (state_q == ST_SHIFT) && out_ready;
    assign word_end = xfer && (bit_q == BIT_W'(WORD_BITS - 1));
    assign clr_last = (clr_q == CLR_W'(CLR_CYCLES - 1));

    // Next-state logic and output decode of the registered state.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        sel_d      = sel_q;
        bit_d      = bit_q;
        clr_d      = clr_q;
        sel        = '0;
        sl         = 1'b0;
        shift_en   = 1'b0;
        bit_cnt    = '0;
        ch_rst     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_tick) begin
                    mask_d = ch_mask;
                    bit_d  = '0;
                    clr_d  = '0;
                    if (first_vld) begin
                        state_d = ST_LOAD;
                        sel_d   = first_idx;
                    end else begin
                        state_d = ST_CLEAR;
                        sel_d   = '0;
                    end
                end
            end
            ST_LOAD: begin
                sl      = 1'b1;
                sel     = sel_q;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sel      = sel_q;
                bit_cnt  = bit_q;
                shift_en = out_ready;
                if (stall_hit) begin
                    state_d = ST_CLEAR;
                    sel_d   = '0;
                    bit_d   = '0;
                    clr_d   = '0;
                end else if (word_end) begin
                    bit_d = '0;
                    if (next_vld) begin
                        state_d = ST_LOAD;
                        sel_d   = next_idx;
                    end else begin
                        state_d = ST_CLEAR;
                        sel_d   = '0;
                        clr_d   = '0;
                    end
                end else if (xfer) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                ch_rst = 1'b1;
                if (clr_last) begin
                    frame_done = 1'b1;
                    clr_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (frame_tick && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    assign overrun = ovr_q;

    // State register with synchronous reset of every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            bit_q   <= '0;
            clr_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            bit_q   <= bit_d;
            clr_q   <= clr_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_spectro_readout_sequencer.sv
// tb/tb_spectro_readout_sequencer.sv - randomized self-checking bench for spectro_readout_sequencer
module tb_spectro_readout_sequencer;

    localparam int NUM_CH    = 16;
    localparam int SEL_W     = 4;
    localparam int WORD_BITS = 12;
    localparam int BIT_W     = 4;
    localparam int DEPTH     = 2048;
`ifdef SEQ_STALL_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic              clk;
    logic              reset;
    logic              frame_tick;
    logic [NUM_CH-1:0] ch_mask;
    logic              out_ready;
    logic              ovr_clr;
    logic [SEL_W-1:0]  sel;
    logic              sl;
    logic              shift_en;
    logic [BIT_W-1:0]  bit_cnt;
    logic              ch_rst;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              timeout;

    int n_pass;
    int n_total;

    // Expected per-cycle trace of one frame, built from the sequencing rules.
    logic              e_sl   [0:DEPTH-1];
    logic [SEL_W-1:0]  e_sel  [0:DEPTH-1];
    logic              e_sh   [0:DEPTH-1];
    logic [BIT_W-1:0]  e_bit  [0:DEPTH-1];
    logic              e_rst  [0:DEPTH-1];
    logic              e_done [0:DEPTH-1];
    logic              e_busy [0:DEPTH-1];
    logic              rdy    [0:DEPTH-1];
    logic              xtk    [0:DEPTH-1];
    logic              xclr   [0:DEPTH-1];
    logic              ovr_m;

    spectro_readout_sequencer #(
        .NUM_CH     (NUM_CH),
        .SEL_W      (SEL_W),
        .WORD_BITS  (WORD_BITS),
        .BIT_W      (BIT_W),
        .CLR_CYCLES (1),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .ch_mask   (ch_mask),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .sel       (sel),
        .sl        (sl),
        .shift_en  (shift_en),
        .bit_cnt   (bit_cnt),
        .ch_rst    (ch_rst),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset      = 1'b1;
        frame_tick = 1'b1;
        ch_mask    = 16'hFFFF;
        out_ready  = 1'b1;
        ovr_clr    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout} !== '0)
            $display("FAIL reset_held: outputs %b, want all 0", {sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout});
        else n_pass++;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        #1;
        n_total++;
        if ({sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout} !== '0)
            $display("FAIL reset_release: outputs %b, want all 0", {sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout});
        else n_pass++;
        ovr_m = 1'b0;
    endtask

    task automatic test_frames();
        logic [15:0] masks [0:7];
        int          done_tab [0:7];
        int          cur, n, last, seen, zr;
        logic        r;
        masks[0] = 16'hFFFF; done_tab[0] = 209;
        masks[1] = 16'h0005; done_tab[1] = 27;
        masks[2] = 16'h0000; done_tab[2] = 1;
        masks[3] = 16'h8000; done_tab[3] = 14;
        for (int f = 4; f < 8; f++) begin
            masks[f]    = 16'($urandom);
            done_tab[f] = -1;
        end
        for (int f = 0; f < 8; f++) begin
            zr = 0;
            for (int t = 0; t < DEPTH; t++) begin
                e_sl[t] = 0; e_sel[t] = '0; e_sh[t] = 0; e_bit[t] = '0;
                e_rst[t] = 0; e_done[t] = 0; e_busy[t] = 0;
                xtk[t] = 0; xclr[t] = 0;
                r = 1'b1;
                if (f >= 4) begin
                    r = ($urandom_range(0, 9) < 7);
                    if (!r) zr++; else zr = 0;
                    if (zr > 4) begin r = 1'b1; zr = 0; end
                end
                rdy[t] = r;
            end
            cur = 1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (masks[f][c]) begin
                    e_sl[cur] = 1; e_sel[cur] = SEL_W'(c); e_busy[cur] = 1;
                    cur++;
                    n = 0;
                    while (n < WORD_BITS) begin
                        e_busy[cur] = 1; e_sel[cur] = SEL_W'(c); e_bit[cur] = BIT_W'(n);
                        e_sh[cur] = rdy[cur];
                        if (rdy[cur]) n++;
                        cur++;
                    end
                end
            end
            e_rst[cur] = 1; e_done[cur] = 1; e_busy[cur] = 1;
            last = cur + 1;
            if (f >= 4) begin
                for (int t = 1; t <= cur; t++) xtk[t] = ($urandom_range(0, 29) == 0);
                for (int t = 0; t <= last; t++) xclr[t] = ($urandom_range(0, 19) == 0);
                if (f == 5) xtk[cur] = 1'b1;
            end
            seen = -1;
            for (int t = 0; t <= last; t++) begin
                @(negedge clk);
                frame_tick = (t == 0) || xtk[t];
                ch_mask    = (t == 0) ? masks[f] : 16'($urandom);
                out_ready  = rdy[t];
                ovr_clr    = xclr[t];
                #1;
                n_total++; if (sl !== e_sl[t]) $display("FAIL f%0d c%0d sl: got %b want %b", f, t, sl, e_sl[t]); else n_pass++;
                n_total++; if (sel !== e_sel[t]) $display("FAIL f%0d c%0d sel: got %0d want %0d", f, t, sel, e_sel[t]); else n_pass++;
                n_total++; if (shift_en !== e_sh[t]) $display("FAIL f%0d c%0d shift_en: got %b want %b", f, t, shift_en, e_sh[t]); else n_pass++;
                n_total++; if (bit_cnt !== e_bit[t]) $display("FAIL f%0d c%0d bit_cnt: got %0d want %0d", f, t, bit_cnt, e_bit[t]); else n_pass++;
                n_total++; if (ch_rst !== e_rst[t]) $display("FAIL f%0d c%0d ch_rst: got %b want %b", f, t, ch_rst, e_rst[t]); else n_pass++;
                n_total++; if (frame_done !== e_done[t]) $display("FAIL f%0d c%0d frame_done: got %b want %b", f, t, frame_done, e_done[t]); else n_pass++;
                n_total++; if (busy !== e_busy[t]) $display("FAIL f%0d c%0d busy: got %b want %b", f, t, busy, e_busy[t]); else n_pass++;
                n_total++; if (overrun !== ovr_m) $display("FAIL f%0d c%0d overrun: got %b want %b", f, t, overrun, ovr_m); else n_pass++;
                n_total++; if (timeout !== 1'b0) $display("FAIL f%0d c%0d timeout: got %b want 0", f, t, timeout); else n_pass++;
                if (frame_done === 1'b1 && seen < 0) seen = t;
                if (xclr[t]) ovr_m = 1'b0;
                if (frame_tick && e_busy[t]) ovr_m = 1'b1;
            end
            if (done_tab[f] >= 0) begin
                n_total++;
                if (seen !== done_tab[f]) $display("FAIL f%0d done_cycle: got %0d want %0d", f, seen, done_tab[f]);
                else n_pass++;
            end
        end
        frame_tick = 1'b0;
        ovr_clr    = 1'b0;
    endtask

    task automatic test_stall();
        for (int t = 0; t <= 215; t++) begin
            @(negedge clk);
            frame_tick = (t == 0);
            ch_mask    = 16'hFFFF;
            out_ready  = !(t >= 47 && t <= 51);
            ovr_clr    = 1'b1;
            #1;
            if (t >= 47 && t <= 51) begin
                n_total++; if (bit_cnt !== 4'd6) $display("FAIL stall c%0d bit_cnt: got %0d want 6", t, bit_cnt); else n_pass++;
                n_total++; if (shift_en !== 1'b0) $display("FAIL stall c%0d shift_en: got %b want 0", t, shift_en); else n_pass++;
                n_total++; if (sel !== 4'd3) $display("FAIL stall c%0d sel: got %0d want 3", t, sel); else n_pass++;
            end
            if (t == 209) begin
                n_total++; if (frame_done !== 1'b0) $display("FAIL stall early_done: got %b want 0", frame_done); else n_pass++;
            end
            if (t == 214) begin
                n_total++; if (frame_done !== 1'b1) $display("FAIL stall done_214: got %b want 1", frame_done); else n_pass++;
                n_total++; if (ch_rst !== 1'b1) $display("FAIL stall ch_rst_214: got %b want 1", ch_rst); else n_pass++;
            end
            if (t == 215) begin
                n_total++; if (busy !== 1'b0) $display("FAIL stall busy_215: got %b want 0", busy); else n_pass++;
            end
        end
        ovr_clr = 1'b0;
    endtask

    task automatic test_overrun();
        for (int t = 0; t <= 211; t++) begin
            @(negedge clk);
            frame_tick = (t == 0) || (t == 50) || (t == 60) || (t == 209);
            ch_mask    = (t == 0) ? 16'hFFFF : 16'h0001;
            out_ready  = 1'b1;
            ovr_clr    = (t == 0) || (t == 60) || (t == 70);
            #1;
            if (t == 1 || t == 50 || t == 71) begin
                n_total++; if (overrun !== 1'b0) $display("FAIL ovr c%0d overrun: got %b want 0", t, overrun); else n_pass++;
            end
            if (t == 51 || t == 61 || t == 70 || t == 210) begin
                n_total++; if (overrun !== 1'b1) $display("FAIL ovr c%0d overrun: got %b want 1", t, overrun); else n_pass++;
            end
            if (t == 196) begin
                n_total++; if ({sl, sel} !== {1'b1, 4'd15}) $display("FAIL ovr last_load: got sl=%b sel=%0d want sl=1 sel=15", sl, sel); else n_pass++;
            end
            if (t == 209) begin
                n_total++; if (frame_done !== 1'b1) $display("FAIL ovr done_209: got %b want 1", frame_done); else n_pass++;
            end
            if (t == 210 || t == 211) begin
                n_total++; if ({busy, sl} !== 2'b00) $display("FAIL ovr c%0d dropped_tick: got busy=%b sl=%b want 0 0", t, busy, sl); else n_pass++;
            end
        end
        frame_tick = 1'b0;
        ovr_clr    = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int seen;
        seen = -1;
        for (int t = 0; t <= 80; t++) begin
            @(negedge clk);
            reset      = (t == 30);
            frame_tick = (t == 0) || (t == 5) || (t == 32);
            ch_mask    = (t == 32) ? 16'h0010 : 16'hFFFF;
            out_ready  = 1'b1;
            ovr_clr    = 1'b0;
            #1;
            if (t == 6) begin
                n_total++; if (overrun !== 1'b1) $display("FAIL rstmid pre_overrun: got %b want 1", overrun); else n_pass++;
            end
            if (t == 31) begin
                n_total++;
                if ({sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout} !== '0)
                    $display("FAIL rstmid outputs: got %b want all 0", {sel, sl, shift_en, bit_cnt, ch_rst, busy, frame_done, overrun, timeout});
                else n_pass++;
            end
            if (t == 33) begin
                n_total++; if ({sl, sel, bit_cnt} !== {1'b1, 4'd4, 4'd0}) $display("FAIL rstmid new_load: got sl=%b sel=%0d bit=%0d want 1 4 0", sl, sel, bit_cnt); else n_pass++;
            end
            if (t > 32 && frame_done === 1'b1 && seen < 0) seen = t;
        end
        frame_tick = 1'b0;
        n_total++;
        if (seen !== 46) $display("FAIL rstmid done_cycle: got %0d want 46", seen); else n_pass++;
    endtask

`ifdef SEQ_STALL_TIMEOUT_EN
    task automatic test_timeout();
        for (int t = 0; t <= 16; t++) begin
            @(negedge clk);
            frame_tick = (t == 0);
            ch_mask    = 16'hFFFF;
            out_ready  = (t < 5);
            ovr_clr    = 1'b0;
            #1;
            if (t == 12) begin
                n_total++; if ({ch_rst, timeout} !== 2'b00) $display("FAIL to c12: got ch_rst=%b timeout=%b want 0 0", ch_rst, timeout); else n_pass++;
            end
            if (t == 13) begin
                n_total++; if ({ch_rst, frame_done} !== 2'b11) $display("FAIL to c13: got ch_rst=%b done=%b want 1 1", ch_rst, frame_done); else n_pass++;
            end
            if (t == 14 || t == 16) begin
                n_total++; if ({timeout, busy} !== 2'b10) $display("FAIL to c%0d: got timeout=%b busy=%b want 1 0", t, timeout, busy); else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        ch_mask    = '0;
        out_ready  = 1'b0;
        ovr_clr    = 1'b0;
        ovr_m      = 1'b0;
        test_reset();
        test_frames();
        test_stall();
        test_overrun();
        test_reset_midframe();
`ifdef SEQ_STALL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
